uart_reg_master: RTL and testbench

- Initiator on the UART peripheral's register interface (`reg_sel`/`wr`/`data_in`/`data_out`); it is the host side that drives the UART block.
- Accepts bytes to transmit on a valid/ready stream. For each byte it loads the data register, then writes the send command to the control register, then polls until the transfer completes.
- Between transmissions it polls for received bytes and delivers them on a valid/ready output stream.

---
 rtl/uart_master_pkg.sv | 26 ++
 rtl/uart_poll_timer.sv | 39 +++
 rtl/uart_reg_master.sv | 161 ++++++++++++++++
 tb/tb_uart_reg_master.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_master_pkg.sv
// Shared types and register-map constants for the UART register-interface master.
package uart_master_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RX_CHK,
    RX_READ,
    RX_CAP,
    RX_CLR,
    TX_DATA,
    TX_CMD,
    TX_WAIT,
    TX_ABORT
  } state_e;

  localparam logic REG_CTRL = 1'b0;
  localparam logic REG_DATA = 1'b1;

  localparam int CTRL_SEND_BIT  = 0;
  localparam int CTRL_RXNEW_BIT = 1;

  localparam logic [7:0] CMD_SEND  = 8'h01;
  localparam logic [7:0] CMD_RXCLR = 8'h02;
  localparam logic [7:0] CMD_ABORT = 8'h00;

endpackage

// File: rtl/uart_poll_timer.sv
// Saturating poll counter: cleared before a send, counts while waiting, flags the limit.
module uart_poll_timer #(
  parameter int POLL_TIMEOUT = 1023
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              clr_i,
  input  logic                              en_i,
  output logic [$clog2(POLL_TIMEOUT+1)-1:0] count_o,
  output logic                              expired_o
);

  localparam int TW = $clog2(POLL_TIMEOUT + 1);
  localparam logic [TW-1:0] LIMIT = TW'(POLL_TIMEOUT);

  logic [TW-1:0] count_q, count_d;

  // Holds at the limit instead of wrapping back to zero.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/uart_reg_master.sv
// Host-side master for the UART register interface: streams bytes out through
// the data/control registers and polls received bytes into an output stream.
module uart_reg_master
  import uart_master_pkg::*;
#(
  parameter int POLL_TIMEOUT = 1023,
  parameter int DATA_W       = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              reg_sel_o,
  output logic              wr_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              busy_o,
  output logic              tx_done_o,
  output logic              timeout_o
);

  state_e state_q, state_d;

  logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rx_valid_q, rx_valid_d;
  logic              reg_sel_q, reg_sel_d;
  logic              wr_q, wr_d;
  logic              tx_done_q, tx_done_d;
  logic              timeout_q, timeout_d;

  logic                              tmr_clr, tmr_en, tmr_expired;
  logic [$clog2(POLL_TIMEOUT+1)-1:0] tmr_count;

  assign tmr_clr = (state_q == TX_CMD);
  assign tmr_en  = (state_q == TX_WAIT);

  uart_poll_timer #(
    .POLL_TIMEOUT(POLL_TIMEOUT)
  ) u_poll_timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .count_o  (tmr_count),
    .expired_o(tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    tx_byte_d  = tx_byte_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    tx_done_d  = 1'b0;
    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (tx_valid_i) begin
          tx_byte_d = tx_data_i;
          state_d   = TX_DATA;
        end else begin
          state_d = RX_CHK;
        end
      end
      // A pending byte is never overwritten; RXNEW stays set until the buffer drains.
      RX_CHK:  state_d = (rdata_i[CTRL_RXNEW_BIT] && !rx_valid_q) ? RX_READ : IDLE;
      RX_READ: state_d = RX_CAP;
      RX_CAP: begin
        rx_data_d  = rdata_i;
        rx_valid_d = 1'b1;
        state_d    = RX_CLR;
      end
      RX_CLR:  state_d = IDLE;
      TX_DATA: state_d = TX_CMD;
      TX_CMD:  state_d = TX_WAIT;
      // Status seen at count zero predates the command write, so it is ignored.
      TX_WAIT: begin
        if ((tmr_count != '0) && !rdata_i[CTRL_SEND_BIT]) begin
          tx_done_d = 1'b1;
          state_d   = IDLE;
        end else if (tmr_expired) begin
          state_d = TX_ABORT;
        end
      end
      TX_ABORT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they come straight from flops.
  always_comb begin
    reg_sel_d = REG_CTRL;
    wr_d      = 1'b0;
    wdata_d   = '0;
    timeout_d = 1'b0;
    case (state_d)
      RX_READ: reg_sel_d = REG_DATA;
      RX_CLR: begin
        wr_d    = 1'b1;
        wdata_d = DATA_W'(CMD_RXCLR);
      end
      TX_DATA: begin
        reg_sel_d = REG_DATA;
        wr_d      = 1'b1;
        wdata_d   = tx_byte_d;
      end
      TX_CMD: begin
        wr_d    = 1'b1;
        wdata_d = DATA_W'(CMD_SEND);
      end
      TX_ABORT: begin
        wr_d      = 1'b1;
        wdata_d   = DATA_W'(CMD_ABORT);
        timeout_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      tx_byte_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      reg_sel_q  <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      tx_done_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_byte_q  <= tx_byte_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      reg_sel_q  <= reg_sel_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      tx_done_q  <= tx_done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign tx_ready_o = (state_q == IDLE);
  assign busy_o     = (state_q != IDLE);
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign reg_sel_o  = reg_sel_q;
  assign wr_o       = wr_q;
  assign wdata_o    = wdata_q;
  assign tx_done_o  = tx_done_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_uart_reg_master.sv
// Bench for uart_reg_master: behavioural UART register model plus write/RX scoreboards.
module tb_uart_reg_master;

  localparam int PT = 16;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i = 1'b1;
  logic       reg_sel_o;
  logic       wr_o;
  logic [7:0] wdata_o;
  logic [7:0] rdata_i = 8'h00;
  logic       busy_o;
  logic       tx_done_o;
  logic       timeout_o;

  always #5 clk_i = ~clk_i;

  uart_reg_master #(
    .POLL_TIMEOUT(PT),
    .DATA_W      (8)
  ) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .tx_data_i (tx_data_i),
    .tx_valid_i(tx_valid_i),
    .tx_ready_o(tx_ready_o),
    .rx_data_o (rx_data_o),
    .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i),
    .reg_sel_o (reg_sel_o),
    .wr_o      (wr_o),
    .wdata_o   (wdata_o),
    .rdata_i   (rdata_i),
    .busy_o    (busy_o),
    .tx_done_o (tx_done_o),
    .timeout_o (timeout_o)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Peripheral model: registered read port, SEND self-clears after clr_delay idle cycles.
  logic       per_send = 1'b0;
  logic       per_rxnew = 1'b0;
  logic [7:0] per_rxdata = 8'h00;
  int         send_cnt = 0;
  int         clr_delay = 10;
  bit         never_clear = 1'b0;
  logic       inj_req = 1'b0;
  logic [7:0] inj_byte = 8'h00;

  always @(posedge clk_i) begin
    if (wr_o && !reg_sel_o) begin
      if (wdata_o[0]) begin
        per_send <= 1'b1;
        send_cnt <= 0;
      end else if (wdata_o == 8'h00) begin
        per_send <= 1'b0;
      end
      if (wdata_o[1]) per_rxnew <= 1'b0;
    end else if (per_send && !never_clear) begin
      if (send_cnt >= clr_delay - 1) per_send <= 1'b0;
      else send_cnt <= send_cnt + 1;
    end
    if (inj_req && !per_rxnew) begin
      per_rxnew  <= 1'b1;
      per_rxdata <= inj_byte;
    end
    rdata_i <= reg_sel_o ? per_rxdata : {6'b0, per_rxnew, per_send};
  end

  logic [8:0] exp_wr_q[$];
  logic [7:0] exp_rx_q[$];
  int cyc = 0, done_cnt = 0, tmo_cnt = 0, wr_cnt = 0, rd_full_cnt = 0;
  int cmd_cyc = 0, abort_cyc = 0, done_at_rx = 0;
  bit chk_drop = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (chk_drop) begin
        check_eq("rx_valid_drop", 32'(rx_valid_o), 32'd0);
        chk_drop = 1'b0;
      end
      if (wr_o) begin
        wr_cnt++;
        if (exp_wr_q.size() == 0) check_eq("wr_unexpected", 32'({reg_sel_o, wdata_o}), 32'hFFFF_FFFF);
        else check_eq("wr_seq", 32'({reg_sel_o, wdata_o}), 32'(exp_wr_q.pop_front()));
        if ({reg_sel_o, wdata_o} == 9'h001) cmd_cyc = cyc;
        if (timeout_o) abort_cyc = cyc;
      end
      if (tx_done_o) done_cnt++;
      if (timeout_o) tmo_cnt++;
      if (rx_valid_o && reg_sel_o && !wr_o) rd_full_cnt++;
      if (rx_valid_o && rx_ready_i) begin
        done_at_rx = done_cnt;
        if (exp_rx_q.size() == 0) check_eq("rx_unexpected", 32'(rx_data_o), 32'hFFFF_FFFF);
        else check_eq("rx_data", 32'(rx_data_o), 32'(exp_rx_q.pop_front()));
        chk_drop = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tx_ready_o && n < 200) begin
      tick();
      n++;
    end
    check_eq("tx_ready_wait", 32'(tx_ready_o), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_abort);
    wait_ready();
    exp_wr_q.push_back({1'b1, b});
    exp_wr_q.push_back(9'h001);
    if (expect_abort) exp_wr_q.push_back(9'h000);
    tx_data_i  = b;
    tx_valid_i = 1'b1;
    tick();
    tx_valid_i = 1'b0;
  endtask

  task automatic inject(input logic [7:0] b);
    int n = 0;
    while (per_rxnew && n < 300) begin
      tick();
      n++;
    end
    check_eq("inject_ready", 32'(per_rxnew), 32'd0);
    exp_rx_q.push_back(b);
    exp_wr_q.push_back(9'h002);
    inj_byte = b;
    inj_req  = 1'b1;
    tick();
    inj_req = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    int n = 0;
    while (done_cnt <= d0 && n < 300) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(done_cnt), 32'(d0 + 1));
  endtask

  task automatic wait_rx_empty(input string tag);
    int n = 0;
    while (exp_rx_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(exp_rx_q.size()), 32'd0);
  endtask

  task automatic ready_soon(input string tag);
    bit seen = 1'b0;
    repeat (3) begin
      if (tx_ready_o) seen = 1'b1;
      tick();
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    int d0, t0, r0, wc, n;
    repeat (3) tick();
    check_eq("rst_wr", 32'(wr_o), 32'd0);
    check_eq("rst_wdata", 32'(wdata_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_rx_valid", 32'(rx_valid_o), 32'd0);
    check_eq("rst_rx_data", 32'(rx_data_o), 32'd0);
    reset_i = 1'b0;
    #1;
    check_eq("rel_tx_ready", 32'(tx_ready_o), 32'd1);

    // TX basic
    d0 = done_cnt;
    send_byte(8'h55, 1'b0);
    wait_done(d0, "tx_basic_done");
    check_eq("tx_basic_writes", 32'(exp_wr_q.size()), 32'd0);
    ready_soon("tx_basic_ready");
    check_eq("tx_basic_once", 32'(done_cnt), 32'(d0 + 1));

    // RX basic
    inject(8'hA3);
    wait_rx_empty("rx_basic_delivered");
    check_eq("rx_basic_data", 32'(rx_data_o), 32'h0A3);

    // RX backpressure
    rx_ready_i = 1'b0;
    inject(8'h11);
    n = 0;
    while (!rx_valid_o && n < 100) begin
      tick();
      n++;
    end
    check_eq("bp_valid", 32'(rx_valid_o), 32'd1);
    inject(8'h22);
    r0 = rd_full_cnt;
    repeat (30) tick();
    check_eq("bp_hold_data", 32'(rx_data_o), 32'h011);
    check_eq("bp_hold_valid", 32'(rx_valid_o), 32'd1);
    check_eq("bp_no_read", 32'(rd_full_cnt), 32'(r0));
    rx_ready_i = 1'b1;
    wait_rx_empty("bp_delivered");
    check_eq("bp_last_data", 32'(rx_data_o), 32'h022);

    // Priority: TX and RXNEW together
    n = 0;
    while ((!tx_ready_o || per_rxnew) && n < 200) begin
      tick();
      n++;
    end
    check_eq("prio_setup", 32'(tx_ready_o), 32'd1);
    d0 = done_cnt;
    exp_wr_q.push_back(9'h1C3);
    exp_wr_q.push_back(9'h001);
    exp_wr_q.push_back(9'h002);
    exp_rx_q.push_back(8'h5A);
    inj_byte   = 8'h5A;
    inj_req    = 1'b1;
    tx_data_i  = 8'hC3;
    tx_valid_i = 1'b1;
    tick();
    inj_req    = 1'b0;
    tx_valid_i = 1'b0;
    wait_rx_empty("prio_rx_delivered");
    check_eq("prio_tx_first", 32'(done_at_rx), 32'(d0 + 1));

    // Timeout
    never_clear = 1'b1;
    t0 = tmo_cnt;
    d0 = done_cnt;
    send_byte(8'h3C, 1'b1);
    n = 0;
    while (tmo_cnt == t0 && n < 100) begin
      tick();
      n++;
    end
    ready_soon("tmo_ready");
    check_eq("tmo_once", 32'(tmo_cnt), 32'(t0 + 1));
    check_eq("tmo_no_done", 32'(done_cnt), 32'(d0));
    check_eq("tmo_latency", 32'(abort_cyc - cmd_cyc), 32'(PT + 2));
    check_eq("tmo_writes", 32'(exp_wr_q.size()), 32'd0);

    // Reset during TX_WAIT
    send_byte(8'h77, 1'b0);
    n = 0;
    while (exp_wr_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    repeat (5) tick();
    check_eq("mid_busy_before", 32'(busy_o), 32'd1);
    reset_i = 1'b1;
    #1;
    check_eq("mid_wr", 32'(wr_o), 32'd0);
    check_eq("mid_reg_sel", 32'(reg_sel_o), 32'd0);
    check_eq("mid_busy", 32'(busy_o), 32'd0);
    check_eq("mid_rx_data", 32'(rx_data_o), 32'd0);
    check_eq("mid_pulses", 32'({tx_done_o, timeout_o}), 32'd0);
    repeat (2) tick();
    reset_i = 1'b0;
    never_clear = 1'b0;
    wc = wr_cnt;
    t0 = tmo_cnt;
    repeat (30) tick();
    check_eq("mid_no_wr", 32'(wr_cnt), 32'(wc));
    check_eq("mid_no_tmo", 32'(tmo_cnt), 32'(t0));
    d0 = done_cnt;
    send_byte(8'h99, 1'b0);
    wait_done(d0, "post_rst_done");

    repeat (5) tick();
    check_eq("end_wr_q", 32'(exp_wr_q.size()), 32'd0);
    check_eq("end_rx_q", 32'(exp_rx_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
